// File: rtl/led_chaser_pkg.sv
// Shared definitions for the icestick LED chaser: pattern modes, init patterns,
// PWM frame constants and the ring-advance helpers.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_BINARY = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [3:0] INIT_RUN    = 4'b0001;
  localparam logic [3:0] INIT_BOUNCE = 4'b0001;
  localparam logic [3:0] INIT_BINARY = 4'b0000;
  localparam logic [3:0] INIT_BLINK  = 4'b1111;

  // Fixed PWM frame length; not a module parameter on purpose.
  localparam int         PWM_PERIOD = 15;
  localparam logic [3:0] PWM_LAST   = 4'(PWM_PERIOD - 1);

  function automatic logic [3:0] init_pattern(input mode_e m);
    logic [3:0] p;
    case (m)
      MODE_RUN:    p = INIT_RUN;
      MODE_BOUNCE: p = INIT_BOUNCE;
      MODE_BINARY: p = INIT_BINARY;
      MODE_BLINK:  p = INIT_BLINK;
      default:     p = INIT_RUN;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] rotate_left(input logic [3:0] p);
    return {p[2:0], p[3]};
  endfunction

  // Bounce turns around at the end LEDs before shifting, so 1000 steps to 0100.
  function automatic dir_e bounce_dir(input logic [3:0] p, input dir_e d);
    dir_e r;
    if (p == 4'b1000) begin
      r = DIR_DOWN;
    end else if (p == 4'b0001) begin
      r = DIR_UP;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_chaser_if.sv
// Control and LED pin bundle of the chaser; the board/driver side is master.
interface led_chaser_if;
  logic       en;
  logic [1:0] mode;
  logic [3:0] duty;
  logic       D1;
  logic       D2;
  logic       D3;
  logic       D4;
  logic       D5;
  logic       tick;

  modport master (
    output en,
    output mode,
    output duty,
    input  D1,
    input  D2,
    input  D3,
    input  D4,
    input  D5,
    input  tick
  );

  modport slave (
    input  en,
    input  mode,
    input  duty,
    output D1,
    output D2,
    output D3,
    output D4,
    output D5,
    output tick
  );
endinterface

// File: rtl/led_prescaler.sv
// Enable-gated clock divider: one-cycle step pulse every PRESCALE enabled cycles.
module led_prescaler #(
  parameter int PRESCALE = 3000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic step
);

  localparam int         CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pscnt_q;
  logic [CW-1:0] pscnt_d;

  // step is qualified by en so dropping en on the terminal count drops the step.
  always_comb begin
    step    = en && (pscnt_q == LAST);
    pscnt_d = pscnt_q;
    if (step) begin
      pscnt_d = '0;
    end else if (en) begin
      pscnt_d = pscnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pscnt_q <= '0;
    end else begin
      pscnt_q <= pscnt_d;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// Ring pattern generator for the icestick LEDs D1..D4 with PWM brightness and
// a D5 heartbeat; every pin is driven straight from a flop.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int PRESCALE = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  led_chaser_if.slave bus
);

  logic       step;

  mode_e      mode_q,    mode_d;
  dir_e       dir_q,     dir_d;
  logic [3:0] pattern_q, pattern_d;
  logic       hb_q,      hb_d;
  logic       tick_q,    tick_d;
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic [3:0] duty_q,    duty_d;
  logic [3:0] leds_q,    leds_d;
  logic       d5_q,      d5_d;

  mode_e      mode_in;
  dir_e       bounce_nxt;
  logic       pwm_on;
  logic [3:0] gated;

  led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .step (step)
  );

  assign mode_in    = mode_e'(bus.mode);
  assign bounce_nxt = bounce_dir(pattern_q, dir_q);
  assign pwm_on     = (duty_q > pwm_cnt_q);

  for (genvar gi = 0; gi < 4; gi++) begin : g_gate
    assign gated[gi] = pattern_q[gi] & pwm_on;
  end

  always_comb begin
    mode_d    = mode_q;
    dir_d     = dir_q;
    pattern_d = pattern_q;
    hb_d      = hb_q;
    tick_d    = step;
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? 4'd0 : pwm_cnt_q + 4'd1;
    duty_d    = (pwm_cnt_q == PWM_LAST) ? bus.duty : duty_q;
    leds_d    = gated;
    d5_d      = hb_q;

    // mode is only looked at on a step, so a pattern never changes mid-step.
    if (step) begin
      hb_d = ~hb_q;
      if (mode_in != mode_q) begin
        mode_d    = mode_in;
        pattern_d = init_pattern(mode_in);
        dir_d     = DIR_UP;
      end else begin
        case (mode_q)
          MODE_RUN: begin
            pattern_d = rotate_left(pattern_q);
          end
          MODE_BOUNCE: begin
            dir_d     = bounce_nxt;
            pattern_d = (bounce_nxt == DIR_UP) ? (pattern_q << 1) : (pattern_q >> 1);
          end
          MODE_BINARY: begin
            pattern_d = pattern_q + 4'd1;
          end
          MODE_BLINK: begin
            pattern_d = ~pattern_q;
          end
          default: begin
            pattern_d = init_pattern(MODE_RUN);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_RUN;
      dir_q     <= DIR_UP;
      pattern_q <= INIT_RUN;
      hb_q      <= 1'b0;
      tick_q    <= 1'b0;
      pwm_cnt_q <= 4'd0;
      duty_q    <= 4'd0;
      leds_q    <= 4'd0;
      d5_q      <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pattern_q <= pattern_d;
      hb_q      <= hb_d;
      tick_q    <= tick_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      leds_q    <= leds_d;
      d5_q      <= d5_d;
    end
  end

  assign bus.D1   = leds_q[0];
  assign bus.D2   = leds_q[1];
  assign bus.D3   = leds_q[2];
  assign bus.D4   = leds_q[3];
  assign bus.D5   = d5_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser with PRESCALE=4: per-step vectors go through a scoreboard,
// PWM, freeze and reset corners are hand-written sequences.
module tb_led_chaser;
  import led_chaser_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_chaser_if bus();

  led_chaser #(
    .PRESCALE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] pins;
    logic       d5;
  } vec_t;

  typedef struct {
    logic [3:0] pins;
    logic       d5;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  logic tick_seen = 1'b0;

  wire [3:0] pins_w = {bus.D4, bus.D3, bus.D2, bus.D1};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] m, input logic [3:0] p, input logic d);
    vec_t v;
    v.mode = m;
    v.pins = p;
    v.d5   = d;
    vecs.push_back(v);
  endtask

  // Pins and D5 are compared one cycle after each tick pulse.
  always @(negedge clk) begin
    exp_t e;
    if (tick_seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step_no++;
      $display("step %0d: pins=%b D5=%b (want %b/%b)", step_no, pins_w, bus.D5, e.pins, e.d5);
      check("step pins", 8'(pins_w), 8'(e.pins));
      check("step D5", 8'(bus.D5), 8'(e.d5));
    end
    tick_seen = bus.tick;
  end

  task automatic run_rows(input int first, input int last);
    exp_t e;
    int   n;
    for (int i = first; i <= last; i++) begin
      bus.mode = vecs[i].mode;
      bus.duty = 4'd15;
      bus.en   = 1'b1;
      e.pins   = vecs[i].pins;
      e.d5     = vecs[i].d5;
      sb_q.push_back(e);
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (sb_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL tick timeout: row %0d got no tick within 20 cycles", i);
        sb_q.delete();
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " pins"}, 8'(pins_w), 8'h0);
    check({name, " D5"}, 8'(bus.D5), 8'h0);
    check({name, " tick"}, 8'(bus.tick), 8'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         on_cnt;
    int         odd_cnt;
    int         n;
    logic [3:0] prev;
    logic [3:0] want;

    // rows 0-4 RUN (duty_q still 0 for the first three steps after reset)
    add_vec(2'b00, 4'b0000, 1'b1);
    add_vec(2'b00, 4'b0000, 1'b0);
    add_vec(2'b00, 4'b0000, 1'b1);
    add_vec(2'b00, 4'b0001, 1'b0);
    add_vec(2'b00, 4'b0010, 1'b1);
    // rows 5-12 BOUNCE: reload, then the reversing sweep
    add_vec(2'b01, 4'b0001, 1'b0);
    add_vec(2'b01, 4'b0010, 1'b1);
    add_vec(2'b01, 4'b0100, 1'b0);
    add_vec(2'b01, 4'b1000, 1'b1);
    add_vec(2'b01, 4'b0100, 1'b0);
    add_vec(2'b01, 4'b0010, 1'b1);
    add_vec(2'b01, 4'b0001, 1'b0);
    add_vec(2'b01, 4'b0010, 1'b1);
    // rows 13-30 BINARY: reload 0000, count 0001..1111, wrap, 0001
    add_vec(2'b10, 4'b0000, 1'b0);
    for (int k = 0; k < 17; k++) begin
      add_vec(2'b10, 4'((k + 1) % 16), 1'((k + 1) % 2));
    end
    // row 31 BLINK reload
    add_vec(2'b11, 4'b1111, 1'b0);
    // rows 32-36 BOUNCE down to 0100
    add_vec(2'b01, 4'b0001, 1'b1);
    add_vec(2'b01, 4'b0010, 1'b0);
    add_vec(2'b01, 4'b0100, 1'b1);
    add_vec(2'b01, 4'b1000, 1'b0);
    add_vec(2'b01, 4'b0100, 1'b1);
    // rows 37-41 after mid-run reset: mode_q back to RUN, so BOUNCE reloads
    add_vec(2'b01, 4'b0000, 1'b1);
    add_vec(2'b01, 4'b0000, 1'b0);
    add_vec(2'b01, 4'b0000, 1'b1);
    add_vec(2'b01, 4'b1000, 1'b0);
    add_vec(2'b01, 4'b0100, 1'b1);

    bus.en   = 1'b1;
    bus.mode = 2'b00;
    bus.duty = 4'd15;
    rst      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    rst = 1'b0;

    run_rows(0, 30);

    bus.en = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("freeze tick", 8'(bus.tick), 8'h0);
      check("freeze pins", 8'(pins_w), 8'h1);
      check("freeze D5", 8'(bus.D5), 8'h1);
    end
    $display("freeze: 20 cycles held at pins=%b D5=%b", pins_w, bus.D5);

    run_rows(31, 31);
    bus.en = 1'b0;

    bus.duty = 4'd0;
    repeat (32) @(negedge clk);
    on_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (pins_w != 4'b0000) on_cnt++;
    end
    $display("pwm duty 0: lit cycles %0d of 30", on_cnt);
    check("duty0 lit cycles", 8'(on_cnt), 8'd0);

    bus.duty = 4'd5;
    repeat (32) @(negedge clk);
    on_cnt  = 0;
    odd_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (pins_w == 4'b1111) on_cnt++;
      else if (pins_w != 4'b0000) odd_cnt++;
    end
    $display("pwm duty 5: lit cycles %0d of 30", on_cnt);
    check("duty5 lit cycles", 8'(on_cnt), 8'd10);
    check("duty5 partial pins", 8'(odd_cnt), 8'd0);

    // Lock onto the start of a lit run, then raise duty mid-frame.
    prev = pins_w;
    n    = 0;
    @(negedge clk);
    while (!(pins_w == 4'b1111 && prev == 4'b0000) && n < 20) begin
      prev = pins_w;
      @(negedge clk);
      n++;
    end
    check("pwm frame start found", 8'(n < 20), 8'd1);
    bus.duty = 4'd15;
    for (int j = 1; j < 30; j++) begin
      @(negedge clk);
      want = (j <= 4 || j >= 15) ? 4'b1111 : 4'b0000;
      check("duty change at frame boundary", 8'(pins_w), 8'(want));
    end
    $display("pwm duty 5->15: change landed at frame boundary");

    run_rows(32, 36);

    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid-run reset");
    $display("mid-run reset: pins=%b D5=%b tick=%b", pins_w, bus.D5, bus.tick);
    rst = 1'b0;

    run_rows(37, 41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
